// File: rtl/train_sequencer_pkg.sv
// Shared training package: sequencer states, default run geometry and the
// output strobe bundle.
package train_sequencer_pkg;

    localparam int unsigned DEF_COUNT_DELAY = 10;
    localparam int unsigned DEF_N_SAMPLES   = 16;
    localparam int unsigned DEF_N_EPOCHS    = 4;
    localparam int unsigned IDX_W           = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FWD,
        BWD,
        ACC,
        UPDATE,
        DONE
    } state_e;

    typedef struct packed {
        logic sample_ready;
        logic fwd_enable;
        logic fwd_sample;
        logic bwd_enable;
        logic bwd_sample;
        logic acc_clear;
        logic acc_en;
        logic upd_en;
        logic busy;
        logic done;
    } ctrl_t;

    // The stage counter spans three stage periods of p cycles.
    function automatic int unsigned stage_cnt_w(input int unsigned p);
        return $clog2(3 * p) + 1;
    endfunction

endpackage

// File: rtl/stage_timer.sv
// Three-stage settle timer shared by the forward and backward passes.
// tick/last describe the cycle that begins at the next clock edge.
module stage_timer
    import train_sequencer_pkg::*;
#(
    parameter int unsigned P = DEF_COUNT_DELAY + 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic last
);

    localparam int unsigned LEN   = 3 * P;
    localparam int unsigned CNT_W = stage_cnt_w(P);
    localparam int unsigned PH_W  = $clog2(P) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PH_W-1:0]  ph_q, ph_d;

    // Wrap counter over the whole pass plus a position within the current stage.
    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        tick  = 1'b0;
        last  = 1'b0;
        if (clr) begin
            cnt_d = '0;
            ph_d  = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
            ph_d  = (ph_q == PH_W'(P - 1)) ? '0 : ph_q + PH_W'(1);
        end
        if (clr || en) begin
            tick = (ph_d == PH_W'(P - 1));
            last = (cnt_d == CNT_W'(LEN - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ph_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

endmodule

// File: rtl/train_sequencer.sv
// Training-run sequencer: steps samples through load, forward, backward and
// accumulate, then applies a weight update per epoch.
module train_sequencer
    import train_sequencer_pkg::*;
#(
    parameter int unsigned COUNT_DELAY = DEF_COUNT_DELAY,
    parameter int unsigned N_SAMPLES   = DEF_N_SAMPLES,
    parameter int unsigned N_EPOCHS    = DEF_N_EPOCHS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             fwd_enable,
    output logic             fwd_sample,
    output logic             bwd_enable,
    output logic             bwd_sample,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             upd_en,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] sample_idx,
    output logic [IDX_W-1:0] epoch_idx
);

    localparam int unsigned P = COUNT_DELAY + 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sample_idx_q, sample_idx_d;
    logic [IDX_W-1:0] epoch_idx_q, epoch_idx_d;
    logic             stage_last_q;
    ctrl_t            out_q, out_d;
    logic             timer_clr, timer_en, timer_tick, timer_last;

    stage_timer #(
        .P(P)
    ) u_stage_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (timer_clr),
        .en    (timer_en),
        .tick  (timer_tick),
        .last  (timer_last)
    );

    // Next state, index updates, timer control and registered Moore outputs.
    always_comb begin
        state_d      = state_q;
        sample_idx_d = sample_idx_q;
        epoch_idx_d  = epoch_idx_q;
        timer_clr    = 1'b0;
        timer_en     = 1'b0;
        out_d        = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    sample_idx_d = '0;
                    epoch_idx_d  = '0;
                end
            end
            LOAD: begin
                if (sample_valid && out_q.sample_ready) begin
                    state_d = FWD;
                end
            end
            FWD: begin
                if (stage_last_q) begin
                    state_d = BWD;
                end
            end
            BWD: begin
                if (stage_last_q) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (sample_idx_q == IDX_W'(N_SAMPLES - 1)) begin
                    state_d = UPDATE;
                end else begin
                    sample_idx_d = sample_idx_q + IDX_W'(1);
                    state_d      = LOAD;
                end
            end
            UPDATE: begin
                sample_idx_d = '0;
                if (epoch_idx_q == IDX_W'(N_EPOCHS - 1)) begin
                    state_d = DONE;
                end else begin
                    epoch_idx_d = epoch_idx_q + IDX_W'(1);
                    state_d     = LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d      = IDLE;
            sample_idx_d = sample_idx_q;
            epoch_idx_d  = epoch_idx_q;
        end

        timer_clr = abort
                 || ((state_d == FWD) && (state_q != FWD))
                 || ((state_d == BWD) && (state_q != BWD));
        timer_en  = (state_d == FWD) || (state_d == BWD);

        out_d.sample_ready = (state_d == LOAD);
        out_d.fwd_enable   = (state_d == FWD);
        out_d.fwd_sample   = (state_d == FWD) && timer_tick;
        out_d.bwd_enable   = (state_d == BWD);
        out_d.bwd_sample   = (state_d == BWD) && timer_tick;
        out_d.acc_clear    = ((state_q == IDLE) && (state_d == LOAD)) || (state_d == UPDATE);
        out_d.acc_en       = (state_d == ACC);
        out_d.upd_en       = (state_d == UPDATE);
        out_d.busy         = (state_d != IDLE);
        out_d.done         = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sample_idx_q <= '0;
            epoch_idx_q  <= '0;
            stage_last_q <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            sample_idx_q <= sample_idx_d;
            epoch_idx_q  <= epoch_idx_d;
            stage_last_q <= timer_last;
            out_q        <= out_d;
        end
    end

    assign sample_ready = out_q.sample_ready;
    assign fwd_enable   = out_q.fwd_enable;
    assign fwd_sample   = out_q.fwd_sample;
    assign bwd_enable   = out_q.bwd_enable;
    assign bwd_sample   = out_q.bwd_sample;
    assign acc_clear    = out_q.acc_clear;
    assign acc_en       = out_q.acc_en;
    assign upd_en       = out_q.upd_en;
    assign busy         = out_q.busy;
    assign done         = out_q.done;
    assign sample_idx   = sample_idx_q;
    assign epoch_idx    = epoch_idx_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Directed bench for train_sequencer: a 2x2 run with P=3 and a 1x1 boundary run.
module tb_train_sequencer;

    logic clk = 1'b0;
    logic reset, start, abort, sample_valid, start_b;

    logic sample_ready, fwd_enable, fwd_sample, bwd_enable, bwd_sample;
    logic acc_clear, acc_en, upd_en, busy, done;
    logic [15:0] sample_idx, epoch_idx;

    logic sample_ready_b, fwd_enable_b, fwd_sample_b, bwd_enable_b, bwd_sample_b;
    logic acc_clear_b, acc_en_b, upd_en_b, busy_b, done_b;
    logic [15:0] sample_idx_b, epoch_idx_b;

    logic [9:0] outs, outs_b;

    int n_chk = 0;
    int n_bad = 0;
    int acc_cnt = 0, upd_cnt = 0, done_cnt = 0, clr_cnt = 0, ovl_cnt = 0;
    int acc_b_cnt = 0, upd_b_cnt = 0;
    int base_acc, base_upd, base_done, base_clr, base_acc_b, base_upd_b;

    assign outs   = {sample_ready, fwd_enable, fwd_sample, bwd_enable, bwd_sample,
                     acc_clear, acc_en, upd_en, busy, done};
    assign outs_b = {sample_ready_b, fwd_enable_b, fwd_sample_b, bwd_enable_b, bwd_sample_b,
                     acc_clear_b, acc_en_b, upd_en_b, busy_b, done_b};

    always #5 clk = ~clk;

    train_sequencer #(
        .COUNT_DELAY (2),
        .N_SAMPLES   (2),
        .N_EPOCHS    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fwd_enable   (fwd_enable),
        .fwd_sample   (fwd_sample),
        .bwd_enable   (bwd_enable),
        .bwd_sample   (bwd_sample),
        .acc_clear    (acc_clear),
        .acc_en       (acc_en),
        .upd_en       (upd_en),
        .busy         (busy),
        .done         (done),
        .sample_idx   (sample_idx),
        .epoch_idx    (epoch_idx)
    );

    train_sequencer #(
        .COUNT_DELAY (2),
        .N_SAMPLES   (1),
        .N_EPOCHS    (1)
    ) dut_b (
        .clk          (clk),
        .reset        (reset),
        .start        (start_b),
        .abort        (abort),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready_b),
        .fwd_enable   (fwd_enable_b),
        .fwd_sample   (fwd_sample_b),
        .bwd_enable   (bwd_enable_b),
        .bwd_sample   (bwd_sample_b),
        .acc_clear    (acc_clear_b),
        .acc_en       (acc_en_b),
        .upd_en       (upd_en_b),
        .busy         (busy_b),
        .done         (done_b),
        .sample_idx   (sample_idx_b),
        .epoch_idx    (epoch_idx_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse counters and exclusivity watch, sampled mid-cycle.
    always @(negedge clk) begin
        if (acc_en)    acc_cnt++;
        if (upd_en)    upd_cnt++;
        if (done)      done_cnt++;
        if (acc_clear) clr_cnt++;
        if (acc_en_b)  acc_b_cnt++;
        if (upd_en_b)  upd_b_cnt++;
        if ((fwd_enable && bwd_enable) || (upd_en && acc_en)) ovl_cnt++;
        if ((fwd_enable_b && bwd_enable_b) || (upd_en_b && acc_en_b)) ovl_cnt++;
    end

    task automatic snap();
        base_acc   = acc_cnt;
        base_upd   = upd_cnt;
        base_done  = done_cnt;
        base_clr   = clr_cnt;
        base_acc_b = acc_b_cnt;
        base_upd_b = upd_b_cnt;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0; start_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_outs", 32'(outs), 0);
        chk("rst_idx", 32'({sample_idx, epoch_idx}), 0);
        chk("rst_outs_b", 32'(outs_b), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_start", 32'(busy), 0);

        // Full run with sample_valid tied high; forward timing checked in detail.
        snap();
        sample_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("load_ready", 32'(sample_ready), 1);
        chk("load_clear", 32'(acc_clear), 1);
        chk("load_busy", 32'(busy), 1);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            chk("fwd_en", 32'(fwd_enable), 1);
            chk("fwd_sample", 32'(fwd_sample), (i % 3 == 2) ? 1 : 0);
            chk("fwd_no_bwd", 32'(bwd_enable), 0);
            @(negedge clk);
        end
        chk("fwd_end", 32'(fwd_enable), 0);
        chk("bwd_start", 32'(bwd_enable), 1);
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        chk("run1_done", 32'(done), 1);
        chk("run1_epoch", 32'(epoch_idx), 1);
        chk("run1_sample", 32'(sample_idx), 0);
        @(negedge clk);
        chk("run1_done_pulse", 32'(done), 0);
        chk("run1_idle", 32'(busy), 0);
        chk("run1_acc", acc_cnt - base_acc, 4);
        chk("run1_upd", upd_cnt - base_upd, 2);
        chk("run1_donecnt", done_cnt - base_done, 1);
        chk("run1_clr", clr_cnt - base_clr, 3);

        // Backpressure in LOAD, ignored start, then abort in BWD cycle 4 of sample 1.
        snap();
        sample_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", 32'(sample_ready), 1);
            chk("bp_no_fwd", 32'(fwd_enable), 0);
            @(negedge clk);
        end
        sample_valid = 1'b1;
        @(negedge clk);
        chk("bp_fwd", 32'(fwd_enable), 1);
        chk("bp_ready_low", 32'(sample_ready), 0);
        for (int i = 0; i < 100 && !(sample_idx == 16'd1 && bwd_enable); i++) @(negedge clk);
        chk("s1_bwd_reached", 32'(sample_idx == 16'd1 && bwd_enable), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_clr", 32'(acc_clear), 0);
        chk("busy_start_idx", 32'(sample_idx), 1);
        chk("busy_start_bwd", 32'(bwd_enable), 1);
        repeat (2) @(negedge clk);
        chk("abort_bwd4", 32'(bwd_enable), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_outs", 32'(outs), 0);
        chk("abort_sidx", 32'(sample_idx), 1);
        chk("abort_eidx", 32'(epoch_idx), 0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", 32'(busy), 0);
        chk("abort_no_upd", upd_cnt - base_upd, 0);
        chk("abort_acc", acc_cnt - base_acc, 1);
        chk("abort_clr", clr_cnt - base_clr, 1);

        // Asynchronous reset between edges in FWD, then a clean full rerun.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !fwd_enable; i++) @(negedge clk);
        chk("ar_fwd_reached", 32'(fwd_enable), 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_outs", 32'(outs), 0);
        chk("ar_idx", 32'({sample_idx, epoch_idx}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("ar_idle", 32'(busy), 0);
        snap();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 300 && !done; i++) @(negedge clk);
        chk("run2_done", 32'(done), 1);
        chk("run2_epoch", 32'(epoch_idx), 1);
        chk("run2_sample", 32'(sample_idx), 0);
        @(negedge clk);
        chk("run2_acc", acc_cnt - base_acc, 4);
        chk("run2_upd", upd_cnt - base_upd, 2);
        chk("run2_donecnt", done_cnt - base_done, 1);

        // Boundary geometry: one sample, one epoch.
        snap();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 40 && !acc_en_b; i++) @(negedge clk);
        chk("b_acc", 32'(acc_en_b), 1);
        chk("b_acc_no_upd", 32'(upd_en_b), 0);
        @(negedge clk);
        chk("b_upd", 32'(upd_en_b), 1);
        chk("b_upd_no_acc", 32'(acc_en_b), 0);
        chk("b_upd_clr", 32'(acc_clear_b), 1);
        @(negedge clk);
        chk("b_done", 32'(done_b), 1);
        chk("b_done_no_upd", 32'(upd_en_b), 0);
        chk("b_idx", 32'({sample_idx_b, epoch_idx_b}), 0);
        @(negedge clk);
        chk("b_idle", 32'(outs_b), 0);
        chk("b_acc_cnt", acc_b_cnt - base_acc_b, 1);
        chk("b_upd_cnt", upd_b_cnt - base_upd_b, 1);

        chk("exclusive_strobes", ovl_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
